// File: rtl/nbcac_21di_encoder_seq.sv
// Sequential NBCAC encoder, 21-bit value to 30-wire codeword.
// Greedy subtraction of one Fibonacci half-weight per clock.
module nbcac_21di_encoder_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [20:0] v,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [29:0] d
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [19:0] r_q, r_d;
  logic [4:0]  k_q, k_d;
  logic [29:0] d_q, d_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [19:0] h;
  logic [4:0]  idx;

  // h(k) = F(31-k); s(k) = 2*h(k) for k >= 2, s(1) = 1 is v[0]
  always_comb begin
    h = 20'd0;
    unique case (k_q)
      5'd2:  h = 20'd514229;
      5'd3:  h = 20'd317811;
      5'd4:  h = 20'd196418;
      5'd5:  h = 20'd121393;
      5'd6:  h = 20'd75025;
      5'd7:  h = 20'd46368;
      5'd8:  h = 20'd28657;
      5'd9:  h = 20'd17711;
      5'd10: h = 20'd10946;
      5'd11: h = 20'd6765;
      5'd12: h = 20'd4181;
      5'd13: h = 20'd2584;
      5'd14: h = 20'd1597;
      5'd15: h = 20'd987;
      5'd16: h = 20'd610;
      5'd17: h = 20'd377;
      5'd18: h = 20'd233;
      5'd19: h = 20'd144;
      5'd20: h = 20'd89;
      5'd21: h = 20'd55;
      5'd22: h = 20'd34;
      5'd23: h = 20'd21;
      5'd24: h = 20'd13;
      5'd25: h = 20'd8;
      5'd26: h = 20'd5;
      5'd27: h = 20'd3;
      5'd28: h = 20'd2;
      5'd29: h = 20'd1;
      5'd30: h = 20'd1;
      default: h = 20'd0;
    endcase
  end

  assign idx = k_q - 5'd1;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    k_d         = k_q;
    d_d         = d_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          r_d        = v[20:1];
          d_d        = {29'd0, v[0]};
          k_d        = 5'd2;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        if (r_q >= h) begin
          d_d[idx] = 1'b1;
          r_d      = r_q - h;
        end
        k_d = k_q + 5'd1;
        if (k_q == 5'd30) begin
          k_d         = 5'd2;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= 20'd0;
      k_q         <= 5'd2;
      d_q         <= 30'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      k_q         <= k_d;
      d_q         <= d_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // a nonzero residual at DONE means the weight table is wrong
  always @(posedge clk) begin
    if (!rst && state_q == DONE)
      assert (r_q == 20'd0);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;

endmodule

// File: tb/tb_nbcac_21di_encoder_seq.sv
// Bench for nbcac_21di_encoder_seq: directed codewords, backpressure,
// mid-run reset and a randomised round trip through a decoder model.
module tb_nbcac_21di_encoder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] v;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] d;

  int errors = 0;
  int checks = 0;

  logic [29:0] exp_q[$];
  logic [20:0] vq[$];

  always #5 clk = ~clk;

  nbcac_21di_encoder_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v         (v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
  );

  // decoder core model: s1 = 1, s(k) = 2*F(31-k)
  function automatic longint decode(input logic [29:0] dd);
    longint a, b, t, sum;
    a   = 1;
    b   = 1;
    sum = longint'(dd[0]);
    for (int k = 30; k >= 2; k--) begin
      if (dd[k-1]) sum += 2 * a;
      t = a + b;
      a = b;
      b = t;
    end
    return sum;
  endfunction

  task automatic send(input logic [20:0] val);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    v        = val;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    v         = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %0b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %0b want 0", out_valid);
    end
    checks++;
    if (d !== 30'h0) begin
      errors++;
      $display("FAIL rst_d: got %h want 0", d);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector(input logic [20:0] val, input logic [29:0] expd);
    int n;
    logic [29:0] e;
    exp_q.push_back(expd);
    send(val);
    wait_out(n);
    checks++;
    if (n != 29) begin
      errors++;
      $display("FAIL latency v=%0d: got %0d want 29", val, n);
    end
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL codeword v=%0d: got %h want %h", val, d, e);
    end
    checks++;
    if (decode(d) != longint'(val)) begin
      errors++;
      $display("FAIL decode v=%0d: got %0d want %0d", val, decode(d), val);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake v=%0d: out_valid=%0b in_ready=%0b want 0/1",
               val, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [29:0] held;
    logic stable;
    send(21'd5);
    repeat (5) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_in_ready: got %0b want 0", in_ready);
    end
    in_valid = 1'b1;
    v        = 21'd999;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%0b want 1", out_valid);
    end
    held     = d;
    stable   = 1'b1;
    in_valid = 1'b1;
    v        = 21'd12345;
    repeat (10) begin
      @(negedge clk);
      if (d !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stable: d=%h ov=%0b ir=%0b want %h/1/0",
               d, out_valid, in_ready, held);
    end
    checks++;
    if (held !== 30'h08000001) begin
      errors++;
      $display("FAIL bp_codeword: got %h want 08000001", held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ir=%0b ov=%0b want 1/0", in_ready, out_valid);
    end
    test_vector(21'd3, 30'h10000001);
  endtask

  task automatic test_reset_mid;
    send(21'd2097151);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 30'h0) begin
      errors++;
      $display("FAIL mid_reset: ir=%0b ov=%0b d=%h want 1/0/0",
               in_ready, out_valid, d);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_vector(21'd1028459, 30'h00000003);
  endtask

  task automatic test_random_round_trip;
    localparam int N = 1000;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic [20:0] rv;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          rv = 21'($urandom);
          if (i == 0) rv = 21'h1FFFFF;
          if (i == 1) rv = 21'h0;
          while (!in_ready) @(negedge clk);
          in_valid = 1'b1;
          v        = rv;
          vq.push_back(rv);
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      begin
        int got;
        int cyc;
        logic [20:0] ev;
        got = 0;
        cyc = 0;
        while (got < N && cyc < N * 60) begin
          if (out_valid && $urandom_range(0, 2) != 0) begin
            checks++;
            if (vq.size() == 0) begin
              errors++;
              $display("FAIL rt_extra: unexpected word d=%h", d);
            end else begin
              ev = vq.pop_front();
              if (decode(d) != longint'(ev)) begin
                errors++;
                $display("FAIL rt_decode #%0d: got %0d want %0d",
                         got, decode(d), ev);
              end
            end
            got++;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
          end else begin
            @(negedge clk);
          end
          cyc++;
        end
        checks++;
        if (got != N) begin
          errors++;
          $display("FAIL rt_timeout: got %0d words want %0d", got, N);
          $fatal(1, "FAIL rt_timeout: round trip stalled");
        end
      end
    join
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL rt_leftover: %0d words not output want 0", vq.size());
    end
  endtask

  initial begin
    test_reset();
    test_vector(21'd0, 30'h00000000);
    test_vector(21'd1, 30'h00000001);
    test_vector(21'd2, 30'h10000000);
    test_vector(21'd3, 30'h10000001);
    test_vector(21'd2097151, 30'h0014A10F);
    test_backpressure();
    test_reset_mid();
    test_random_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
